// File: rtl/spectral_pkg.sv
// Shared types and arithmetic helpers for the spectral filter.
package spectral_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_LP     = 2'd1,
    MODE_HP     = 2'd2,
    MODE_BP     = 2'd3
  } mode_e;

  // Round half-up then saturate a product of a signed sample and an unsigned
  // Q1.(gain_w-1) gain back into a signed width-bit range. The result is
  // returned sign-extended to 64 bits; callers keep the low width bits.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] p,
                                                   input int unsigned       width,
                                                   input int unsigned       gain_w);
    logic signed [63:0] r;
    logic signed [63:0] hi_lim;
    logic signed [63:0] lo_lim;
    r      = (p + (64'sd1 <<< (gain_w - 2))) >>> (gain_w - 1);
    hi_lim = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo_lim = -(64'sd1 <<< (width - 1));
    if (r > hi_lim) begin
      r = hi_lim;
    end else if (r < lo_lim) begin
      r = lo_lim;
    end
    return r;
  endfunction

  // Fold bin k of an n-point frame onto its Hermitian mirror distance.
  function automatic int unsigned mirror_bin(input int unsigned k, input int unsigned n);
    return (k <= n / 2) ? k : n - k;
  endfunction

endpackage

// File: rtl/spectral_filter_if.sv
// Input and output bin streams of the spectral filter, with frame markers.
interface spectral_filter_if #(
  parameter int WIDTH = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_r;
  logic signed [WIDTH-1:0] in_i;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_r;
  logic signed [WIDTH-1:0] out_i;
  logic                    out_last;
  logic                    frame_done;

  // Upstream source / downstream sink side (drives inputs, consumes outputs).
  modport master (
    output in_valid, in_r, in_i, out_ready,
    input  in_ready, out_valid, out_r, out_i, out_last, frame_done
  );

  // Filter side.
  modport slave (
    input  in_valid, in_r, in_i, out_ready,
    output in_ready, out_valid, out_r, out_i, out_last, frame_done
  );
endinterface

// File: rtl/spectral_filter_cplx_scale.sv
// Output stage: one complex bin times the pass-band gain, rounded and
// saturated, or passed through untouched in bypass, or zeroed if rejected.
module cplx_scale
  import spectral_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int GAIN_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic                    bypass,
  input  logic                    pass,
  input  logic [GAIN_W-1:0]       gain,
  input  logic signed [WIDTH-1:0] in_r,
  input  logic signed [WIDTH-1:0] in_i,
  input  logic                    in_last,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] out_r,
  output logic signed [WIDTH-1:0] out_i,
  output logic                    out_last
);

  logic                    out_valid_q, out_valid_d;
  logic signed [WIDTH-1:0] out_r_q, out_r_d;
  logic signed [WIDTH-1:0] out_i_q, out_i_d;
  logic                    out_last_q, out_last_d;

  function automatic logic signed [WIDTH-1:0] scale(input logic signed [WIDTH-1:0] x,
                                                   input logic [GAIN_W-1:0]       g);
    logic signed [63:0] p;
    p = 64'(x) * 64'($signed({1'b0, g}));
    return WIDTH'(round_sat(p, WIDTH, GAIN_W));
  endfunction

  // Next output bin; everything holds while the stream is stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    out_r_d     = out_r_q;
    out_i_d     = out_i_q;
    out_last_d  = out_last_q;
    if (en) begin
      out_valid_d = in_valid;
      out_last_d  = in_valid && in_last;
      if (bypass) begin
        out_r_d = in_r;
        out_i_d = in_i;
      end else if (pass) begin
        out_r_d = scale(in_r, gain);
        out_i_d = scale(in_i, gain);
      end else begin
        out_r_d = '0;
        out_i_d = '0;
      end
    end
  end

  // S2 registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_i_q     <= '0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      out_i_q     <= out_i_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign out_i     = out_i_q;
  assign out_last  = out_last_q;

endmodule

// File: rtl/spectral_filter.sv
// Frequency-domain mask between forward and inverse FFT: bin counter,
// per-frame config latch, Hermitian mask decode, S1 register and handshake.
module spectral_filter
  import spectral_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int LOG2N  = 6,
  parameter int GAIN_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        cfg_mode,
  input  logic [LOG2N-1:0]  cfg_lo_bin,
  input  logic [LOG2N-1:0]  cfg_hi_bin,
  input  logic [GAIN_W-1:0] cfg_gain,
  spectral_filter_if.slave  bus
);

  localparam int unsigned       N        = 2 ** LOG2N;
  localparam logic [LOG2N-1:0]  LAST_BIN = '1;
  localparam logic [GAIN_W-1:0] GAIN_ONE = {1'b1, {(GAIN_W-1){1'b0}}};

  logic              en, hs, first;
  logic [LOG2N-1:0]  in_cnt_q, in_cnt_d;
  mode_e             mode_q, mode_d, eff_mode;
  logic [LOG2N-1:0]  lo_q, lo_d, eff_lo;
  logic [LOG2N-1:0]  hi_q, hi_d, eff_hi;
  logic [GAIN_W-1:0] gain_q, gain_d, eff_gain;
  logic [LOG2N-1:0]  e_bin;
  logic              pass;

  logic                    s1_valid_q, s1_valid_d;
  logic signed [WIDTH-1:0] s1_r_q, s1_r_d;
  logic signed [WIDTH-1:0] s1_i_q, s1_i_d;
  logic                    s1_pass_q, s1_pass_d;
  logic                    s1_bypass_q, s1_bypass_d;
  logic [GAIN_W-1:0]       s1_gain_q, s1_gain_d;
  logic                    s1_last_q, s1_last_d;

  logic                    out_valid;
  logic signed [WIDTH-1:0] out_r, out_i;
  logic                    out_last;

  // Handshake, config selection, mask decode and S1 next state. Bin 0 is
  // decoded with the live cfg_* because that is the cycle they get latched.
  always_comb begin
    en    = !out_valid || bus.out_ready;
    hs    = bus.in_valid && en;
    first = (in_cnt_q == '0);

    eff_mode = first ? mode_e'(cfg_mode) : mode_q;
    eff_lo   = first ? cfg_lo_bin : lo_q;
    eff_hi   = first ? cfg_hi_bin : hi_q;
    eff_gain = first ? cfg_gain   : gain_q;

    e_bin = LOG2N'(mirror_bin(32'(in_cnt_q), N));
    pass  = 1'b0;
    unique case (eff_mode)
      MODE_BYPASS: pass = 1'b1;
      MODE_LP:     pass = (e_bin <= eff_hi);
      MODE_HP:     pass = (e_bin >= eff_lo);
      MODE_BP:     pass = (e_bin >= eff_lo) && (e_bin <= eff_hi);
    endcase

    in_cnt_d = in_cnt_q;
    mode_d   = mode_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    gain_d   = gain_q;
    if (hs) begin
      in_cnt_d = in_cnt_q + 1'b1;
      if (first) begin
        mode_d = eff_mode;
        lo_d   = eff_lo;
        hi_d   = eff_hi;
        gain_d = eff_gain;
      end
    end

    s1_valid_d  = s1_valid_q;
    s1_r_d      = s1_r_q;
    s1_i_d      = s1_i_q;
    s1_pass_d   = s1_pass_q;
    s1_bypass_d = s1_bypass_q;
    s1_gain_d   = s1_gain_q;
    s1_last_d   = s1_last_q;
    if (en) begin
      s1_valid_d = hs;
    end
    if (hs) begin
      s1_r_d      = bus.in_r;
      s1_i_d      = bus.in_i;
      s1_pass_d   = pass;
      s1_bypass_d = (eff_mode == MODE_BYPASS);
      s1_gain_d   = eff_gain;
      s1_last_d   = (in_cnt_q == LAST_BIN);
    end
  end

  // Bin counter, config latch and S1 registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_cnt_q    <= '0;
      mode_q      <= MODE_BYPASS;
      lo_q        <= '0;
      hi_q        <= LAST_BIN;
      gain_q      <= GAIN_ONE;
      s1_valid_q  <= 1'b0;
      s1_r_q      <= '0;
      s1_i_q      <= '0;
      s1_pass_q   <= 1'b0;
      s1_bypass_q <= 1'b0;
      s1_gain_q   <= '0;
      s1_last_q   <= 1'b0;
    end else begin
      in_cnt_q    <= in_cnt_d;
      mode_q      <= mode_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      gain_q      <= gain_d;
      s1_valid_q  <= s1_valid_d;
      s1_r_q      <= s1_r_d;
      s1_i_q      <= s1_i_d;
      s1_pass_q   <= s1_pass_d;
      s1_bypass_q <= s1_bypass_d;
      s1_gain_q   <= s1_gain_d;
      s1_last_q   <= s1_last_d;
    end
  end

  cplx_scale #(
    .WIDTH  (WIDTH),
    .GAIN_W (GAIN_W)
  ) u_scale (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in_valid  (s1_valid_q),
    .bypass    (s1_bypass_q),
    .pass      (s1_pass_q),
    .gain      (s1_gain_q),
    .in_r      (s1_r_q),
    .in_i      (s1_i_q),
    .in_last   (s1_last_q),
    .out_valid (out_valid),
    .out_r     (out_r),
    .out_i     (out_i),
    .out_last  (out_last)
  );

  assign bus.in_ready   = en;
  assign bus.out_valid  = out_valid;
  assign bus.out_r      = out_r;
  assign bus.out_i      = out_i;
  assign bus.out_last   = out_last;
  assign bus.frame_done = out_valid && bus.out_ready && out_last;

endmodule

// File: tb/tb_spectral_filter.sv
// Directed and back-pressured checks of spectral_filter (N=64, Q1.7 gain).
module tb_spectral_filter;

  localparam int WIDTH  = 16;
  localparam int LOG2N  = 6;
  localparam int GAIN_W = 8;
  localparam int N      = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] cfg_mode;
  logic [5:0] cfg_lo_bin, cfg_hi_bin;
  logic [7:0] cfg_gain;

  spectral_filter_if #(.WIDTH(WIDTH)) bus();

  spectral_filter #(.WIDTH(WIDTH), .LOG2N(LOG2N), .GAIN_W(GAIN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_mode   (cfg_mode),
    .cfg_lo_bin (cfg_lo_bin),
    .cfg_hi_bin (cfg_hi_bin),
    .cfg_gain   (cfg_gain),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct { int r; int i; bit last; } out_t;
  typedef struct { int fr; int k; int er; int ei; } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  out_t cap[$];
  out_t expq[$];
  int   fd_cnt = 0;
  int   cyc = 0;
  int   hs0_cyc = -1;
  int   first_cyc = -1;
  bit   rand_ready = 1'b0;
  int   tb_k = 0;
  int   fr_mode, fr_lo, fr_hi, fr_gain;

  logic signed [15:0] hold_r, hold_i;
  logic               hold_last;
  bit                 stall_prev = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Independent reference: Hermitian mask plus floor((x*g + 64)/128), clamped.
  function automatic int model(input int mode, lo, hi, gain, k, x);
    int     e;
    bit     pass;
    longint v, q;
    e = (k <= N / 2) ? k : N - k;
    case (mode)
      0:       pass = 1'b1;
      1:       pass = (e <= hi);
      2:       pass = (e >= lo);
      default: pass = (e >= lo) && (e <= hi);
    endcase
    if (mode == 0) return x;
    if (!pass) return 0;
    v = longint'(x) * gain + 64;
    q = v / 128;
    if ((v % 128 != 0) && (v < 0)) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    bus.out_ready = rand_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
  end

  // Output monitor: capture accepted bins, count frame_done, check stall stability.
  always @(negedge clk) begin
    if (!reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_r", bus.out_r, hold_r);
        chk("stall_i", bus.out_i, hold_i);
        chk("stall_last", bus.out_last, hold_last);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (first_cyc < 0) first_cyc = cyc;
        cap.push_back('{int'(bus.out_r), int'(bus.out_i), bus.out_last});
      end
      if (bus.frame_done) fd_cnt++;
      stall_prev = bus.out_valid && !bus.out_ready;
      hold_r     = bus.out_r;
      hold_i     = bus.out_i;
      hold_last  = bus.out_last;
    end
  end

  task automatic send_bin(input int r, input int i, input int gap_pct);
    int guard;
    bit acc;
    while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_r     = 16'(r);
    bus.in_i     = 16'(i);
    acc   = 1'b0;
    guard = 0;
    while (!acc) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      guard++;
      if (guard > 200) begin
        n_err++;
        $display("FAIL in_ready_timeout: bin %0d not accepted within 200 cycles", tb_k);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1);
      end
    end
    expq.push_back('{model(fr_mode, fr_lo, fr_hi, fr_gain, tb_k, r),
                     model(fr_mode, fr_lo, fr_hi, fr_gain, tb_k, i),
                     (tb_k == N - 1)});
    tb_k = (tb_k + 1) % N;
    bus.in_valid = 1'b0;
  endtask

  // pat: 0 ramp (k, -k), 1 constant (cval, -cval), 2 random.
  task automatic run_frame(input int mode, lo, hi, gain, pat, cval, gap,
                           input int chg_at, cmode, clo, chi, input bit scramble);
    int r, i;
    fr_mode = mode; fr_lo = lo; fr_hi = hi; fr_gain = gain;
    for (int k = 0; k < N; k++) begin
      case (pat)
        0:       begin r = k;    i = -k;    end
        1:       begin r = cval; i = -cval; end
        default: begin
          r = int'($urandom_range(0, 65535)) - 32768;
          i = int'($urandom_range(0, 65535)) - 32768;
        end
      endcase
      if (k == 0) begin
        cfg_mode = 2'(mode); cfg_lo_bin = 6'(lo); cfg_hi_bin = 6'(hi); cfg_gain = 8'(gain);
      end else if (k == chg_at) begin
        cfg_mode = 2'(cmode); cfg_lo_bin = 6'(clo); cfg_hi_bin = 6'(chi);
      end else if (scramble) begin
        cfg_mode   = 2'($urandom_range(0, 3));
        cfg_lo_bin = 6'($urandom_range(0, 63));
        cfg_hi_bin = 6'($urandom_range(0, 63));
        cfg_gain   = 8'($urandom_range(0, 255));
      end
      send_bin(r, i, gap);
      if (k == 0 && hs0_cyc < 0) hs0_cyc = cyc;
    end
  endtask

  task automatic drain();
    rand_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask

  vec_t vt[$];
  out_t got;
  int   j, bad;

  initial begin
    vt = '{
      '{0, 0, 0, 0}, '{0, 1, 1, -1}, '{0, 32, 32, -32}, '{0, 63, 63, -63},
      '{1, 1, 1, -1}, '{1, 4, 4, -4}, '{1, 5, 0, 0}, '{1, 59, 0, 0}, '{1, 60, 60, -60}, '{1, 63, 63, -63},
      '{2, 0, 0, 0}, '{2, 2, 0, 0}, '{2, 3, 1500, -1500}, '{2, 5, 1500, -1500}, '{2, 6, 0, 0},
      '{2, 58, 0, 0}, '{2, 59, 1500, -1500}, '{2, 61, 1500, -1500}, '{2, 62, 0, 0},
      '{3, 4, 32767, -32768}, '{3, 60, 32767, -32768}, '{3, 10, 0, 0},
      '{4, 0, 0, 0}, '{4, 2, 0, 0}, '{4, 10, 0, 0}, '{4, 32, 0, 0}, '{4, 62, 0, 0},
      '{5, 2, 2, -2}, '{5, 20, 0, 0}, '{5, 30, 0, 0}, '{5, 62, 62, -62},
      '{6, 2, 0, 0}, '{6, 9, 0, 0}, '{6, 10, 10, -10}, '{6, 30, 30, -30}, '{6, 54, 54, -54}, '{6, 55, 0, 0}
    };

    bus.in_valid = 1'b0; bus.in_r = '0; bus.in_i = '0; bus.out_ready = 1'b1;
    cfg_mode = 2'd0; cfg_lo_bin = 6'd0; cfg_hi_bin = 6'd63; cfg_gain = 8'h80;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_r", bus.out_r, 0);
    chk("rst_out_i", bus.out_i, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Directed frames, back-to-back, no stalls.
    cap.delete(); fd_cnt = 0;
    run_frame(0, 0, 63, 8'h80, 0, 0, 0, 99, 0, 0, 0, 1'b0);
    run_frame(1, 0, 4, 8'h80, 0, 0, 0, 99, 0, 0, 0, 1'b0);
    run_frame(3, 3, 5, 8'hC0, 1, 1000, 0, 99, 0, 0, 0, 1'b0);
    run_frame(3, 3, 5, 8'hC0, 1, 30000, 0, 99, 0, 0, 0, 1'b0);
    run_frame(3, 10, 2, 8'hC0, 1, 1000, 0, 99, 0, 0, 0, 1'b0);
    run_frame(1, 0, 4, 8'h80, 0, 0, 0, 20, 2, 10, 63, 1'b0);
    run_frame(2, 10, 63, 8'h80, 0, 0, 0, 99, 0, 0, 0, 1'b0);
    drain();

    // Handshake at edge c, out_valid seen after edge c+1: 2-cycle latency.
    chk("latency_edges", first_cyc - hs0_cyc, 1);
    chk("dir_count", cap.size(), 7 * N);
    chk("dir_frame_done", fd_cnt, 7);
    bad = 0;
    for (int m = 0; m < cap.size(); m++)
      if (cap[m].last != ((m % N) == N - 1)) bad++;
    chk("dir_last_flags", bad, 0);
    for (int v = 0; v < vt.size(); v++) begin
      j = vt[v].fr * N + vt[v].k;
      got = (j < cap.size()) ? cap[j] : '{99999, 99999, 1'b0};
      chk($sformatf("vec_f%0d_k%0d_r", vt[v].fr, vt[v].k), got.r, vt[v].er);
      chk($sformatf("vec_f%0d_k%0d_i", vt[v].fr, vt[v].k), got.i, vt[v].ei);
    end

    // Reset in the middle of a frame, with the pipeline full.
    fr_mode = 1; fr_lo = 0; fr_hi = 4; fr_gain = 8'h80;
    cfg_mode = 2'd1; cfg_lo_bin = 6'd0; cfg_hi_bin = 6'd4; cfg_gain = 8'h80;
    for (int k = 0; k < 30; k++) send_bin(1000, -1000, 0);
    bus.in_valid = 1'b1; bus.in_r = 16'sd1000; bus.in_i = -16'sd1000;
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_r", bus.out_r, 0);
    chk("midrst_out_i", bus.out_i, 0);
    chk("midrst_out_last", bus.out_last, 0);
    chk("midrst_frame_done", bus.frame_done, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    tb_k = 0;
    cap.delete(); fd_cnt = 0;
    run_frame(1, 0, 4, 8'h80, 1, 1000, 0, 99, 0, 0, 0, 1'b0);
    drain();
    chk("postrst_count", cap.size(), N);
    got = (cap.size() > 0) ? cap[0] : '{99999, 99999, 1'b0};
    chk("postrst_bin0_r", got.r, 1000);
    chk("postrst_bin0_i", got.i, -1000);
    got = (cap.size() > 5) ? cap[5] : '{99999, 99999, 1'b0};
    chk("postrst_bin5_r", got.r, 0);
    got = (cap.size() > 63) ? cap[63] : '{99999, 99999, 1'b0};
    chk("postrst_bin63_r", got.r, 1000);
    chk("postrst_bin63_last", got.last, 1);
    chk("postrst_frame_done", fd_cnt, 1);

    // Back-pressure: random stalls, input gaps, config scrambled mid-frame.
    cap.delete(); expq.delete(); fd_cnt = 0;
    rand_ready = 1'b1;
    run_frame(3, 3, 5, 8'hC0, 2, 0, 25, 99, 0, 0, 0, 1'b1);
    run_frame(1, 0, 7, 8'h60, 2, 0, 25, 99, 0, 0, 0, 1'b1);
    run_frame(2, 20, 63, 8'hFF, 2, 0, 25, 99, 0, 0, 0, 1'b1);
    run_frame(0, 0, 63, 8'h80, 2, 0, 25, 99, 0, 0, 0, 1'b1);
    drain();
    chk("bp_count", cap.size(), 4 * N);
    chk("bp_frame_done", fd_cnt, 4);
    for (int m = 0; m < expq.size(); m++) begin
      got = (m < cap.size()) ? cap[m] : '{99999, 99999, 1'b0};
      chk($sformatf("bp_bin%0d_r", m), got.r, expq[m].r);
      chk($sformatf("bp_bin%0d_i", m), got.i, expq[m].i);
      chk($sformatf("bp_bin%0d_last", m), got.last, expq[m].last);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spectral_filter.md
# spectral_filter

Parametrised frequency-domain filter between the forward FFT and the inverse FFT in the FFT filtering chain. Accepts frames of N complex bins over a valid/ready stream and applies a per-frame selected mask: bypass, low-pass, high-pass or band-pass. Pass bins are scaled by a programmable gain; rejected bins are zeroed. The mask is Hermitian-symmetric, so a real input signal stays real after the inverse FFT. It replaces the fixed filter and its reset-as-start sequencing with a back-pressured stream that carries a frame marker.

## Interface
- WIDTH, 16: signed width of each real/imag component.
- LOG2N, 6: log2 of frame length; N = 2**LOG2N bins.
- GAIN_W, 8: unsigned gain width, format Q1.(GAIN_W-1); 2**(GAIN_W-1) = 1.0.
- clk  in  1  clock; rising edge.
- reset  in  1  asynchronous, active-low reset.
- cfg_mode  in  2  0 bypass, 1 low-pass, 2 high-pass, 3 band-pass.
- cfg_lo_bin  in  LOG2N  lower cutoff bin, inclusive.
- cfg_hi_bin  in  LOG2N  upper cutoff bin, inclusive.
- cfg_gain  in  GAIN_W  pass-band gain.
- in_valid  in  1  input bin valid.
- in_ready  out  1  block accepts input this cycle.
- in_r, in_i  in  WIDTH  input bin, signed.
- out_valid  out  1  output bin valid.
- out_ready  in  1  downstream accepts output.
- out_r, out_i  out  WIDTH  output bin, signed.
- out_last  out  1  output is bin N-1 of its frame.
- frame_done  out  1  one-cycle pulse on the handshake of the last bin.

## Operation
- Bin index k: in_cnt counts input handshakes and wraps from N-1 to 0. Bin 0 starts a frame.
- Config latch: cfg_* are sampled on the handshake of bin 0 and held for the whole frame. Changes mid-frame take effect at the next frame.
- Mirrored index: e = k for k <= N/2, otherwise e = N-k.
- Pass condition per mode:
  - bypass: all bins pass.
  - low-pass: e <= hi.
  - high-pass: e >= lo.
  - band-pass: lo <= e <= hi. If lo > hi, every bin is rejected.
- Bypass output equals the input bit-exactly, with no gain, rounding or saturation.
- Pass bin, non-bypass mode, per component:
  - p = x * gain, signed WIDTH times unsigned GAIN_W, giving a WIDTH+GAIN_W result.
  - Add 2**(GAIN_W-2), then shift right arithmetically by GAIN_W-1 (round half-up).
  - Saturate to [-2**(WIDTH-1), 2**(WIDTH-1)-1].
- Rejected bin: out_r = out_i = 0.
- out_last and frame_done come from the input bin index carried down the pipeline, not from a separate output counter.

## Timing
- Two-stage pipeline:
  - S1 registers input, k, pass flag and latched gain/mode.
  - S2 registers the rounded, saturated product and the last flag.
- Latency is 2 cycles from input handshake to out_valid, with out_ready held high. Throughput is 1 bin per cycle.
- Global advance: en = !out_valid || out_ready, and in_ready = en (combinational). An S1 bubble may sit behind a stalled S2; no bubble collapsing.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_r, out_i and out_last stay stable.
  - Input is accepted only when in_valid && in_ready.
- frame_done = out_valid && out_ready && out_last.
- Values during and after reset:
  - out_valid, out_r, out_i, out_last, frame_done all 0.
  - in_ready is 1.
  - in_cnt is 0.
  - Latched config is bypass, lo = 0, hi = N-1, gain = 1.0.
- Reset mid-frame:
  - The pipeline is flushed and the partial frame discarded.
  - The first handshake after reset release is bin 0.
- Back-to-back frames: bin N-1 of frame F and bin 0 of frame F+1 may be accepted on consecutive cycles. The config latch then updates in the same cycle as the bin 0 handshake.

## Structure
- Package spectral_pkg holds:
  - the mode enum: MODE_BYPASS, MODE_LP, MODE_HP, MODE_BP;
  - a round_sat function parametrised on WIDTH and GAIN_W;
  - the mirrored-index helper.
- Sub-module cplx_scale: one complex bin times the gain, with rounding and saturation. It is registered as S2 and instantiated once.
- spectral_filter holds the bin counter, config latch, mask decode, S1 and the handshake logic.

## Test plan
- Bypass, N=64: feed in_r = k, in_i = -k for k = 0..63.
  - Output equals input exactly, 2 cycles after each handshake.
  - out_last and frame_done fire on bin 63 only.
- Low-pass, hi = 4, gain = 0x80:
  - Bins 0-4 and 60-63 pass unchanged.
  - Bins 5-59 output 0+0j.
- Band-pass, lo = 3, hi = 5, gain = 0xC0 (1.5), input 1000 + -1000j on every bin:
  - Bins 3-5 and 59-61 give 1500 + -1500j.
  - Input 30000 saturates to 32767; input -30000 saturates to -32768.
  - All other bins are 0.
  - A second case with lo = 10, hi = 2 zeroes every bin.
- Back-pressure: random out_ready at 30%, random in_valid gaps.
  - Output sequence matches the reference model bin-for-bin.
  - Output holds stable while stalled.
  - No loss or duplication across 4 back-to-back frames.
- Config and reset:
  - Change cfg_mode from LP to HP at bin 20: the current frame stays LP, the next frame is HP.
  - Assert reset at bin 30: all outputs read 0, and the next input is treated as bin 0.
